div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 173 +++++++++++++++++
 tb/tb_div_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer with stall/cancel handshake
//
// Purpose: signed/unsigned WIDTH-bit divide, one restoring step per cycle on
// operand magnitudes, followed by a single sign-fix cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, is_signed      request a divide (sampled in IDLE) and its signedness
//   dividend, divisor     operands, sampled with start
//   cancel                flush kill, aborts any operation next edge
//   stall                 pipeline hold request while a divide is in progress
//   busy                  high whenever not IDLE
//   done                  one-cycle result-valid pulse
//   hilo                  registered result {remainder, quotient}
module div_sequencer #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 cancel,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   hilo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [5:0]         r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH:0]     w_dvs_abs;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept   = (r_state == S_IDLE) && start && !cancel;
    assign w_div_zero = (divisor == '0);
    assign w_dvd_neg  = is_signed && dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed && divisor[WIDTH-1];

    // The most negative dividend negates to 2^(WIDTH-1), which is still
    // representable as an unsigned WIDTH-bit magnitude.
    assign w_dvd_abs  = w_dvd_neg ? -dividend : dividend;
    // Divisor magnitude carried with one extra bit so the compare below
    // treats 2^(WIDTH-1) as a plain positive value.
    assign w_dvs_abs  = w_dvs_neg ? -{divisor[WIDTH-1], divisor} : {1'b0, divisor};

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract only when the divisor fits. The partial remainder stays
    // below the divisor, so it never needs more than WIDTH bits.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= r_dvs);
    assign w_sub      = WIDTH'(w_shift - r_dvs);
    assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    stall        = 1'b1;
                    w_state_next = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall = !cancel;
                if (r_cnt == 6'(CYCLES - 1)) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                stall        = !cancel;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = !cancel;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (cancel) begin
            w_state_next = S_IDLE;
        end
        // Inputs may toggle while reset is held; keep the hold request quiet.
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            hilo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_quo   <= w_dvd_abs;
                        r_dvs   <= w_dvs_abs;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        // Divide by zero skips CALC/FIX and enters DONE directly.
                        if (w_div_zero) begin
                            hilo <= {dividend, {WIDTH{1'b1}}};
                        end
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_FIX: begin
                    r_cnt <= '0;
                    if (!cancel) begin
                        hilo <= {w_rem_fix, w_quo_fix};
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer with latency/result model
module tb_div_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          cancel = 1'b0;
    logic          stall;
    logic          busy;
    logic          done;
    logic [2*W-1:0] hilo;

    int tests = 0;
    int fails = 0;

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .stall(stall), .busy(busy), .done(done), .hilo(hilo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: an accepted request becomes visible as done a
    // fixed number of edges later unless cancelled first.
    bit          m_active;
    int          m_left;
    logic [63:0] m_hilo;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_left   = 0;
            m_hilo   = '0;
        end else if (m_active) begin
            if (cancel || m_left == 0) begin
                m_active = 0;
            end else begin
                m_left--;
                if (m_left == 0) m_hilo = m_res;
            end
        end else if (start && !cancel) begin
            m_active = 1;
            m_res    = ref_div(is_signed, dividend, divisor);
            m_left   = (divisor == 0) ? 0 : W + 1;
            if (m_left == 0) m_hilo = m_res;
        end
    end

    always @(negedge clk) begin
        logic e_stall, e_busy, e_done;
        if (rst) begin
            e_stall = 0; e_busy = 0; e_done = 0;
        end else begin
            e_busy  = m_active;
            e_done  = m_active && m_left == 0 && !cancel;
            e_stall = m_active ? (m_left > 0 && !cancel) : (start && !cancel);
        end
        chk("cyc_stall", 64'(stall), 64'(e_stall));
        chk("cyc_busy",  64'(busy),  64'(e_busy));
        chk("cyc_done",  64'(done),  64'(e_done));
        chk("cyc_hilo",  hilo, m_hilo);
    end

    // Issues one request and waits (bounded) for done. lat is cycles from the
    // start cycle to the done cycle, -1 on timeout. Optionally re-asserts start
    // with other operands dis_at cycles after the start cycle.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int dis_at, input logic [31:0] da, input logic [31:0] db,
                         output int lat, output int stalls);
        @(posedge clk); #1;
        start = 1; is_signed = s; dividend = a; divisor = b;
        lat = -1; stalls = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
            start = 0;
            if (cyc + 1 == dis_at) begin
                start = 1; dividend = da; divisor = db;
            end
        end
        start = 0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, stalls, cnt;
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stalls, cnt;

        chk("mdl_100_7",   ref_div(0, 100, 7),                       64'h00000002_0000000E);
        chk("mdl_m7_2",    ref_div(1, 32'hFFFFFFF9, 2),              64'hFFFFFFFF_FFFFFFFD);
        chk("mdl_ovf",     ref_div(1, 32'h80000000, 32'hFFFFFFFF),   64'h00000000_80000000);
        chk("mdl_dz",      ref_div(0, 32'h1234, 0),                  64'h00001234_FFFFFFFF);

        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        chk("rst_hilo", hilo, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        do_op(0, 100, 7, -1, 0, 0, lat, stalls);
        chk("u_lat",    64'(lat), 64'd34);
        chk("u_stalls", 64'(stalls), 64'd34);
        chk("u_hilo",   hilo, 64'h00000002_0000000E);

        do_op(1, 32'hFFFFFFF9, 2, -1, 0, 0, lat, stalls);
        chk("s_hilo", hilo, 64'hFFFFFFFF_FFFFFFFD);

        do_op(1, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, lat, stalls);
        chk("ovf_hilo", hilo, 64'h00000000_80000000);

        do_op(0, 32'h1234, 0, -1, 0, 0, lat, stalls);
        chk("dz_lat",  64'(lat), 64'd1);
        chk("dz_hilo", hilo, 64'h00001234_FFFFFFFF);

        // Cancel at CALC iteration 10.
        @(posedge clk); #1;
        start = 1; is_signed = 0; dividend = 500; divisor = 3;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1 cancel = 1;
        @(posedge clk); #1 cancel = 0;
        @(negedge clk);
        chk("cancel_busy", 64'(busy), 64'h0);
        count_done(40, cnt);
        chk("cancel_nodone", 64'(cnt), 64'h0);
        chk("cancel_hilo", hilo, 64'h00001234_FFFFFFFF);
        do_op(0, 1000, 10, -1, 0, 0, lat, stalls);
        chk("after_cancel_lat",  64'(lat), 64'd34);
        chk("after_cancel_hilo", hilo, 64'h00000000_00000064);

        // Second start during CALC must be ignored.
        do_op(0, 50, 5, 5, 9, 3, lat, stalls);
        chk("busy_start_lat",  64'(lat), 64'd34);
        chk("busy_start_hilo", hilo, 64'h00000000_0000000A);

        // Asynchronous reset mid-CALC.
        @(posedge clk); #1;
        start = 1; is_signed = 0; dividend = 77; divisor = 3;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_stall", 64'(stall), 64'h0);
        chk("arst_busy",  64'(busy),  64'h0);
        chk("arst_done",  64'(done),  64'h0);
        chk("arst_hilo",  hilo, 64'h0);
        #2 rst = 0;
        count_done(40, cnt);
        chk("arst_nodone", 64'(cnt), 64'h0);

        // Start presented during reset is accepted on the first edge after release.
        @(posedge clk); #2 rst = 1;
        start = 1; is_signed = 0; dividend = 12; divisor = 4;
        #2 rst = 0;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("first_edge_busy", 64'(busy), 64'h1);
        count_done(40, cnt);
        chk("first_edge_done", 64'(cnt), 64'h1);
        chk("first_edge_hilo", hilo, 64'h00000000_00000003);

        // Randomized traffic: overlapping starts, zero divisors, sign corners, cancels.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 3) == 0);
            is_signed = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       dividend = 32'h80000000;
                1:       dividend = $urandom_range(0, 20);
                default: dividend = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       divisor = 0;
                1:       divisor = 32'hFFFFFFFF;
                2:       divisor = $urandom_range(1, 15);
                3:       divisor = 32'h80000000;
                default: divisor = $urandom;
            endcase
            cancel = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        start = 0; cancel = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
